// File: rtl/firtap_loader.sv
// Coefficient loader for an adjustable-tap FIR chain: a host-written shadow RAM
// is shifted into the taps on request, followed by a one-cycle pipeline clear.
module firtap_loader #(
  parameter int NTAPS   = 16,
  parameter int LGNTAPS = 4,
  parameter int TW      = 16
) (
  input  logic               i_clk,
  input  logic               i_areset_n,
  input  logic               i_coef_wr,
  input  logic [LGNTAPS-1:0] i_coef_addr,
  input  logic [TW-1:0]      i_coef_data,
  input  logic               i_reload,
  input  logic               i_ce,
  output logic               o_ce,
  output logic               o_tap_wr,
  output logic [TW-1:0]      o_tap,
  output logic               o_fir_reset,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_LOAD, S_FLUSH} state_t;

  // One extra bit so the counter can step past address 0 and mark the last LOAD cycle.
  localparam int CW = LGNTAPS + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tap_wr_q, tap_wr_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic            fir_reset_q, fir_reset_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            dropped_q, dropped_d;
  logic            ram_we;
  logic            ce;
  logic [TW-1:0]   ram_q [NTAPS];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_wr_d    = 1'b0;
    tap_d       = '0;
    fir_reset_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    dropped_d   = dropped_q;
    ram_we      = 1'b0;
    ce          = 1'b0;
    case (state_q)
      S_IDLE: begin
        ce     = i_ce;
        ram_we = i_coef_wr;
        if (i_reload) begin
          state_d   = S_PRIME;
          cnt_d     = CW'(NTAPS - 1);
          dropped_d = 1'b0;
        end
      end
      // The read register doubles as o_tap, so each read lands on the chain one clock later.
      S_PRIME, S_LOAD: begin
        if (!cnt_q[CW-1]) begin
          tap_wr_d = 1'b1;
          tap_d    = ram_q[cnt_q[LGNTAPS-1:0]];
          cnt_d    = cnt_q - 1'b1;
          state_d  = S_LOAD;
        end else begin
          fir_reset_d = 1'b1;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      if (i_ce) dropped_d = 1'b1;
      if (i_coef_wr || i_reload) err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tap_wr_q    <= 1'b0;
      tap_q       <= '0;
      fir_reset_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_wr_q    <= tap_wr_d;
      tap_q       <= tap_d;
      fir_reset_q <= fir_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dropped_q   <= dropped_d;
    end
  end

  // Shadow RAM keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (ram_we) ram_q[i_coef_addr] <= i_coef_data;
  end

  assign o_ce        = ce;
  assign o_tap_wr    = tap_wr_q;
  assign o_tap       = tap_q;
  assign o_fir_reset = fir_reset_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_dropped   = dropped_q;

endmodule
